// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
//   fetch_state_e : request engine FSM states
//   WORD_BYTES    : instruction bus word size in bytes
//   fetch_rsp_t   : one fetched word as pushed into the fetch FIFO
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    localparam int unsigned WORD_BYTES = 4;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] addr;
    } fetch_rsp_t;

endpackage

// File: rtl/instr_fetch_req_ctrl.sv
// Instruction-bus request engine feeding the prefetch FIFO.
// Issues word-aligned reads on req/gnt/rvalid, tracks up to NUM_REQS
// outstanding requests, drops responses made stale by a redirect and pushes
// the surviving words, tagged with their address, into the fetch FIFO.
// Ports:
//   clk, rstn                     clock, async active-low reset
//   redirect_i, redirect_pc_i     restart fetch at a new PC
//   fifo_free_i                   free entries in the fetch FIFO
//   instr_req_o/gnt_i/addr_o      bus request channel
//   instr_rvalid_i/rdata_i/err_i  bus response channel
//   rsp_valid_o/rdata_o/err_o/addr_o  push into the fetch FIFO (zero latency)
//   busy_o                        requests outstanding or pending
module instr_fetch_req_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0]  PC_RESET = 32'h0000_0000,
    parameter int unsigned  NUM_REQS = 2,
    localparam int unsigned CNT_W    = $clog2(NUM_REQS + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_pc_i,
    input  logic [CNT_W-1:0] fifo_free_i,
    output logic             instr_req_o,
    input  logic             instr_gnt_i,
    output logic [31:0]      instr_addr_o,
    input  logic             instr_rvalid_i,
    input  logic [31:0]      instr_rdata_i,
    input  logic             instr_err_i,
    output logic             rsp_valid_o,
    output logic [31:0]      rsp_rdata_o,
    output logic             rsp_err_o,
    output logic [31:0]      rsp_addr_o,
    output logic             busy_o
);

    localparam logic [31:0]      ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0]      PC_START   = PC_RESET & ALIGN_MASK;
    localparam logic [31:0]      STEP       = 32'(WORD_BYTES);
    localparam logic [CNT_W-1:0] MAX_OUT    = CNT_W'(NUM_REQS);

    fetch_state_e     state_q;
    logic [31:0]      fetch_addr_q;   // address of the next request to issue
    logic [31:0]      req_addr_q;     // address currently driven on the bus
    logic [31:0]      rsp_addr_q;     // address of the next non-stale response
    logic [CNT_W-1:0] outstanding_q;
    logic [CNT_W-1:0] discard_q;
    logic             pend_stale_q;   // pending request was overtaken by a redirect
    logic             halt_q;         // error seen, stop issuing until redirect

    logic             gnt_acc;
    logic             stale_gnt;
    logic             rsp_push;
    logic             rsp_drop;
    logic             halt_n;
    logic             issue_ok;
    logic [CNT_W-1:0] out_gnt;
    logic [CNT_W-1:0] disc_gnt;
    logic [CNT_W-1:0] out_n;
    logic [CNT_W-1:0] disc_n;
    logic [31:0]      redirect_pc;
    logic [31:0]      fetch_addr_n;
    fetch_rsp_t       rsp;

    assign redirect_pc = redirect_pc_i & ALIGN_MASK;
    assign gnt_acc     = (state_q == REQ) && instr_gnt_i;
    assign stale_gnt   = gnt_acc && pend_stale_q;
    assign rsp_push    = instr_rvalid_i && (discard_q == '0) && !redirect_i;
    assign rsp_drop    = instr_rvalid_i && (discard_q != '0) && !redirect_i;

    // Counters after this cycle's grant but before its response: the issue
    // decision ignores same-cycle responses so a word just pushed (not yet
    // reflected in fifo_free_i) can never cause the FIFO to be overcommitted.
    assign out_gnt  = outstanding_q + CNT_W'(gnt_acc);
    assign disc_gnt = discard_q + CNT_W'(stale_gnt);
    assign out_n    = out_gnt - CNT_W'(instr_rvalid_i);
    // On redirect everything still in flight (including this cycle's grant) is stale.
    assign disc_n   = redirect_i ? out_n : disc_gnt - CNT_W'(rsp_drop);
    assign halt_n   = !redirect_i && (halt_q || (rsp_push && instr_err_i));
    assign issue_ok = (out_gnt < MAX_OUT) && ((out_gnt - disc_gnt) < fifo_free_i)
                      && !redirect_i && !halt_n;

    // A stale grant already had its successor address replaced by the redirect PC.
    assign fetch_addr_n = redirect_i                ? redirect_pc :
                          (gnt_acc && !pend_stale_q) ? fetch_addr_q + STEP :
                                                      fetch_addr_q;

    // FSM, counters and address registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            fetch_addr_q  <= PC_START;
            req_addr_q    <= PC_START;
            rsp_addr_q    <= PC_START;
            outstanding_q <= '0;
            discard_q     <= '0;
            pend_stale_q  <= 1'b0;
            halt_q        <= 1'b0;
        end else begin
            outstanding_q <= out_n;
            discard_q     <= disc_n;
            halt_q        <= halt_n;
            fetch_addr_q  <= fetch_addr_n;

            if (gnt_acc) begin
                pend_stale_q <= 1'b0;
            end else if (redirect_i && (state_q == REQ)) begin
                pend_stale_q <= 1'b1;
            end

            if (redirect_i) begin
                rsp_addr_q <= redirect_pc;
            end else if (rsp_push) begin
                rsp_addr_q <= rsp_addr_q + STEP;
            end

            case (state_q)
                IDLE: begin
                    if (halt_n) begin
                        state_q <= HALT;
                    end else if (issue_ok) begin
                        state_q    <= REQ;
                        req_addr_q <= fetch_addr_n;
                    end
                end
                // The request is never retracted or re-addressed before its grant.
                REQ: begin
                    if (instr_gnt_i) begin
                        if (issue_ok) begin
                            req_addr_q <= fetch_addr_n;
                        end else if (halt_n) begin
                            state_q <= HALT;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                HALT: begin
                    if (redirect_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp = '{rdata: instr_rdata_i, err: instr_err_i, addr: rsp_addr_q};

    assign instr_req_o  = (state_q == REQ);
    assign instr_addr_o = req_addr_q;
    assign rsp_valid_o  = rsp_push;
    assign rsp_rdata_o  = rsp.rdata;
    assign rsp_err_o    = rsp.err;
    assign rsp_addr_o   = rsp.addr;
    assign busy_o       = (outstanding_q != '0) || (state_q == REQ);

    // Bus protocol and counter sanity.
    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rstn)
        instr_rvalid_i |-> (outstanding_q != '0));
    a_discard_bound: assert property (@(posedge clk) disable iff (!rstn)
        discard_q <= outstanding_q);
    a_req_stable: assert property (@(posedge clk) disable iff (!rstn)
        (instr_req_o && !instr_gnt_i) |=> (instr_req_o && $stable(instr_addr_o)));

endmodule

// File: tb/tb_instr_fetch_req_ctrl.sv
// Self-checking bench for instr_fetch_req_ctrl (PC_RESET = 0x102, NUM_REQS = 2).
// Directed stimulus; expected FIFO pushes go into a scoreboard queue and a
// negedge monitor compares every push the DUT presents.
module tb_instr_fetch_req_ctrl;
    import fetch_pkg::*;

    localparam int unsigned NR   = 2;
    localparam int unsigned CW   = $clog2(NR + 1);
    localparam logic [31:0] DMASK = 32'hDEAD_BEEF;

    logic          clk;
    logic          rstn;
    logic          redirect_i;
    logic [31:0]   redirect_pc_i;
    logic [CW-1:0] fifo_free_i;
    logic          instr_req_o;
    logic          instr_gnt_i;
    logic [31:0]   instr_addr_o;
    logic          instr_rvalid_i;
    logic [31:0]   instr_rdata_i;
    logic          instr_err_i;
    logic          rsp_valid_o;
    logic [31:0]   rsp_rdata_o;
    logic          rsp_err_o;
    logic [31:0]   rsp_addr_o;
    logic          busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_rsp_t  exp_q[$];
    logic [31:0] gnt_q[$];
    fetch_rsp_t  mon_exp;
    fetch_rsp_t  mon_act;

    instr_fetch_req_ctrl #(
        .PC_RESET (32'h0000_0102),
        .NUM_REQS (NR)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .fifo_free_i    (fifo_free_i),
        .instr_req_o    (instr_req_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_addr_o   (instr_addr_o),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_err_i    (instr_err_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .rsp_addr_o     (rsp_addr_o),
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Answer the oldest granted request; queue the expected push if it survives.
    task automatic respond(input logic err, input logic push, input logic [31:0] addr);
        logic [31:0] ga;
        ga = 32'h0;
        if (gnt_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL no_grant: got no granted request, expected one for %h", addr);
        end else begin
            ga = gnt_q.pop_front();
        end
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = ga ^ DMASK;
        instr_err_i    = err;
        if (push) exp_q.push_back('{rdata: addr ^ DMASK, err: err, addr: addr});
    endtask

    task automatic rsp_idle();
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = 32'h0;
        instr_err_i    = 1'b0;
    endtask

    // Monitor: record grants, check every FIFO push against the scoreboard.
    always @(negedge clk) begin
        if (rstn) begin
            if (instr_req_o && instr_gnt_i) gnt_q.push_back(instr_addr_o);
            if (rsp_valid_o) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_push: got push addr %h, expected no push", rsp_addr_o);
                end else begin
                    mon_exp = exp_q.pop_front();
                    mon_act = '{rdata: rsp_rdata_o, err: rsp_err_o, addr: rsp_addr_o};
                    if (mon_act !== mon_exp) begin
                        n_fail++;
                        $display("FAIL push: got data %h err %b addr %h, expected data %h err %b addr %h",
                                 mon_act.rdata, mon_act.err, mon_act.addr,
                                 mon_exp.rdata, mon_exp.err, mon_exp.addr);
                    end
                end
            end
        end
    end

    initial begin
        rstn          = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        fifo_free_i   = CW'(3);
        instr_gnt_i   = 1'b0;
        rsp_idle();
        repeat (3) tick();
        check("rst_req",   32'(instr_req_o), 32'd0);
        check("rst_busy",  32'(busy_o), 32'd0);
        check("rst_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_addr",  instr_addr_o, 32'h100);
        rstn = 1'b1;

        // Grant withheld three cycles: request and address must hold.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_req",  32'(instr_req_o), 32'd1);
            check("hold_addr", instr_addr_o, 32'h100);
        end
        check("hold_busy", 32'(busy_o), 32'd1);
        instr_gnt_i = 1'b1;
        tick();
        check("b2b_req",  32'(instr_req_o), 32'd1);
        check("b2b_addr", instr_addr_o, 32'h104);
        tick();
        check("sat_req",  32'(instr_req_o), 32'd0);
        check("sat_busy", 32'(busy_o), 32'd1);
        instr_gnt_i = 1'b0;
        tick();
        check("sat_req2", 32'(instr_req_o), 32'd0);

        // Redirect with 0x100/0x104 in flight: both responses discarded.
        redirect_i = 1'b1; redirect_pc_i = 32'h2000;
        tick();
        redirect_i = 1'b0;
        check("redir_idle", 32'(instr_req_o), 32'd0);
        tick();
        respond(1'b0, 1'b0, 32'h0);
        tick();
        respond(1'b0, 1'b0, 32'h0);
        tick();
        rsp_idle();
        check("redir_req",  32'(instr_req_o), 32'd1);
        check("redir_addr", instr_addr_o, 32'h2000);
        instr_gnt_i = 1'b1;
        tick();
        instr_gnt_i = 1'b0;
        check("post_addr", instr_addr_o, 32'h2004);
        respond(1'b0, 1'b1, 32'h2000);
        tick();
        rsp_idle();

        // Redirect while 0x2004 is pending un-granted.
        redirect_i = 1'b1; redirect_pc_i = 32'h3000;
        tick();
        redirect_i = 1'b0;
        check("pend_req",  32'(instr_req_o), 32'd1);
        check("pend_addr", instr_addr_o, 32'h2004);
        instr_gnt_i = 1'b1;
        tick();
        instr_gnt_i = 1'b0;
        check("pend_next", instr_addr_o, 32'h3000);
        respond(1'b0, 1'b0, 32'h0);
        tick();
        rsp_idle();
        instr_gnt_i = 1'b1;
        tick();
        instr_gnt_i = 1'b0;
        check("seq_addr", instr_addr_o, 32'h3004);
        respond(1'b0, 1'b1, 32'h3000);
        tick();
        rsp_idle();

        // Error response halts issue; later responses still drain.
        instr_gnt_i = 1'b1;
        tick();
        check("err_pre_addr", instr_addr_o, 32'h3008);
        tick();
        instr_gnt_i = 1'b0;
        check("err_pre_req", 32'(instr_req_o), 32'd0);
        respond(1'b1, 1'b1, 32'h3004);
        tick();
        respond(1'b0, 1'b1, 32'h3008);
        check("halt_req", 32'(instr_req_o), 32'd0);
        tick();
        rsp_idle();
        check("halt_req2", 32'(instr_req_o), 32'd0);
        check("halt_busy", 32'(busy_o), 32'd0);
        tick();
        check("halt_req3", 32'(instr_req_o), 32'd0);
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0403;
        tick();
        redirect_i = 1'b0;
        check("resume_idle", 32'(instr_req_o), 32'd0);
        tick();
        check("resume_req",  32'(instr_req_o), 32'd1);
        check("resume_addr", instr_addr_o, 32'h400);

        // FIFO credit: one non-stale outstanding blocks issue until free = 2.
        fifo_free_i = CW'(1);
        instr_gnt_i = 1'b1;
        tick();
        instr_gnt_i = 1'b0;
        check("credit_block", 32'(instr_req_o), 32'd0);
        tick();
        check("credit_block2", 32'(instr_req_o), 32'd0);
        fifo_free_i = CW'(2);
        tick();
        check("credit_req",  32'(instr_req_o), 32'd1);
        check("credit_addr", instr_addr_o, 32'h404);

        // Grant and response in the same cycle leave one outstanding.
        instr_gnt_i = 1'b1;
        respond(1'b0, 1'b1, 32'h400);
        tick();
        instr_gnt_i = 1'b0;
        rsp_idle();
        fifo_free_i = CW'(0);
        check("same_req",  32'(instr_req_o), 32'd0);
        check("same_busy", 32'(busy_o), 32'd1);
        tick();
        check("same_busy2", 32'(busy_o), 32'd1);
        respond(1'b0, 1'b1, 32'h404);
        tick();
        rsp_idle();
        check("drain_busy", 32'(busy_o), 32'd0);
        check("drain_req",  32'(instr_req_o), 32'd0);
        check("sb_empty",   32'(exp_q.size()), 32'd0);
        check("gnt_empty",  32'(gnt_q.size()), 32'd0);

        // Asynchronous reset in the middle of a pending request.
        fifo_free_i = CW'(3);
        tick();
        check("final_req",  32'(instr_req_o), 32'd1);
        check("final_addr", instr_addr_o, 32'h408);
        #2 rstn = 1'b0;
        #1;
        check("arst_req",  32'(instr_req_o), 32'd0);
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_addr", instr_addr_o, 32'h100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_req_ctrl.md
Name: instr_fetch_req_ctrl

Overview:
Instruction-bus request engine directly upstream of the fetch stage's prefetch FIFO. It issues word-aligned read requests on the req/gnt/rvalid instruction bus and tracks up to NUM_REQS outstanding requests. It discards responses made stale by a PC redirect (branch, trap or flush). Surviving response words are pushed in order, tagged with their word address, into the fetch FIFO.

Parameters:
PC_RESET, 32'h0000_0000, first fetch address after reset; bits [1:0] ignored.
NUM_REQS, 2, maximum outstanding (granted, not yet rvalid) requests; must be >= 1.

Ports:
clk  in  1  clock
rstn  in  1  reset; asynchronous, active-low
redirect_i  in  1  restart fetch at redirect_pc_i; all in-flight responses become stale
redirect_pc_i  in  32  new fetch PC; bits [1:0] ignored
fifo_free_i  in  CNT_W  free entries in the downstream fetch FIFO this cycle
instr_req_o  out  1  bus request
instr_gnt_i  in  1  bus grant
instr_addr_o  out  32  request address, always [1:0]=2'b00
instr_rvalid_i  in  1  response valid
instr_rdata_i  in  32  response data
instr_err_i  in  1  response bus error, valid with rvalid
rsp_valid_o  out  1  push strobe into the fetch FIFO
rsp_rdata_o  out  32  pushed word, equal to instr_rdata_i
rsp_err_o  out  1  pushed word carries a bus error
rsp_addr_o  out  32  word address of the pushed word
busy_o  out  1  outstanding_q != 0 or a request is pending

Behaviour:
- Reset values:
  - instr_req_o = 0; rsp_valid_o = 0; busy_o = 0.
  - fetch_addr_q = {PC_RESET[31:2], 2'b00}; rsp_addr_q = the same value.
  - outstanding_q = 0; discard_q = 0; FSM = IDLE.
- Counters:
  - outstanding_q and discard_q are each CNT_W bits wide, range 0..NUM_REQS, where CNT_W = $clog2(NUM_REQS+1).
  - Invariant: discard_q <= outstanding_q.
- FSM states: IDLE, REQ, HALT.
- IDLE -> REQ when all of the following hold; instr_req_o = 1 and instr_addr_o = fetch_addr_q in REQ:
  - outstanding_q < NUM_REQS;
  - (outstanding_q - discard_q) < fifo_free_i;
  - no redirect_i this cycle.
- Bus stability rule: in REQ, instr_req_o and instr_addr_o are held stable until gnt. A request cannot be retracted or re-addressed.
- REQ with gnt:
  - fetch_addr_q += 4, wrapping mod 2^32;
  - outstanding_q increments;
  - next state is REQ if the issue condition still holds for the next cycle, otherwise IDLE (back-to-back issue allowed).
- Redirect:
  - fetch_addr_q and rsp_addr_q load {redirect_pc_i[31:2], 2'b00};
  - discard_q loads outstanding_q + gnt_this_cycle - rvalid_this_cycle;
  - any rvalid in the redirect cycle is dropped;
  - FSM leaves HALT.
- Redirect while REQ is pending un-granted: pend_stale_q is set. When the grant arrives it increments both outstanding_q and discard_q and clears pend_stale_q. The next request then carries the new address.
- Response arriving with discard_q != 0: rsp_valid_o = 0, discard_q and outstanding_q decrement, rsp_addr_q unchanged.
- Response arriving with discard_q == 0 and no redirect:
  - rsp_valid_o = 1, combinational with zero latency; rsp_rdata_o and rsp_err_o pass through;
  - rsp_addr_o = rsp_addr_q, then rsp_addr_q += 4;
  - outstanding_q decrements.
- gnt and rvalid in the same cycle: outstanding_q is unchanged.
- Error: a pushed response with instr_err_i = 1 moves the FSM to HALT after any pending grant completes. No new requests are issued in HALT. Outstanding responses still drain: they are pushed normally, and later ones are not suppressed. Only redirect_i leaves HALT.
- Protocol violation, covered by assertion only: instr_rvalid_i while outstanding_q == 0.
- Async reset mid-transaction returns all state to reset values immediately. A bus response arriving after reset is a protocol violation.

Decomposition:
- fetch_pkg holds:
  - the fsm state typedef (IDLE, REQ, HALT);
  - the WORD_BYTES = 4 constant;
  - the fetch response struct {rdata, err, addr}, shared with the fetch stage FIFO.
- No sub-module. The FSM, the two counters and the two address registers stay in one block.

Test Plan:
- Reset with PC_RESET = 32'h0000_0102 and fifo_free_i = 3, gnt tied 1 -> first instr_addr_o = 0x100, then 0x104. outstanding_q saturates at 2 and instr_req_o drops until an rvalid arrives.
- Gnt withheld 3 cycles -> instr_req_o and instr_addr_o = 0x100 stable all 3 cycles. Single grant -> outstanding_q = 1.
- Two requests outstanding (0x100, 0x104), redirect_i to 0x2000 -> the next two rvalids give rsp_valid_o = 0. The next request is 0x2000 and its response gives rsp_addr_o = 0x2000.
- Redirect to 0x3000 while REQ is pending un-granted at 0x108 -> the 0x108 grant completes, its response is discarded, and the next request is 0x3000.
- Response with instr_err_i = 1 at 0x104 -> rsp_err_o = 1 and no further requests. A redirect to 0x400 resumes fetch at 0x400.
- fifo_free_i = 1 with one non-stale request outstanding -> no issue until fifo_free_i = 2. gnt and rvalid in the same cycle -> outstanding_q constant.
